// File: rtl/vid_timing_pkg.sv
// Shared video timing defaults, counter type and transmit FSM encoding
// for the HDMI output path (640x480 @ 60 Hz, 25.2 MHz pixel clock).
package vid_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic [23:0] DEF_UFLOW_COLOR = 24'hFF00FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

endpackage

// File: rtl/vid_hv_counter.sv
// Horizontal/vertical raster counters with active-region and sync decode.
// Counters advance only while run is high and sit at zero otherwise.
module vid_hv_counter
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic active,
  output logic hs_n,
  output logic vs_n,
  output logic frame_end
);

  localparam cnt_t H_LAST     = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_ACT_END  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_END  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START   = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END     = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START   = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END     = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  // Syncs are negative polarity: low only inside the sync window.
  assign active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs_n      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_n      = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/hdmi_tx_out.sv
// Raster generator feeding an ADV7513: requests pixels from the frame buffer,
// aligns returned data with DE/HS/VS two clocks later and flags underflow.
module hdmi_tx_out
  import vid_timing_pkg::*;
#(
  parameter int          H_ACTIVE    = DEF_H_ACTIVE,
  parameter int          H_FP        = DEF_H_FP,
  parameter int          H_SYNC      = DEF_H_SYNC,
  parameter int          H_BP        = DEF_H_BP,
  parameter int          V_ACTIVE    = DEF_V_ACTIVE,
  parameter int          V_FP        = DEF_V_FP,
  parameter int          V_SYNC      = DEF_V_SYNC,
  parameter int          V_BP        = DEF_V_BP,
  parameter logic [23:0] UFLOW_COLOR = DEF_UFLOW_COLOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        pix_rd,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        hdmi_de,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic [23:0] hdmi_d,
  output logic        frame_start,
  output logic        underflow,
  output logic        busy
);

  tx_state_t state;
  tx_state_t state_next;
  logic      drain_cnt;
  logic      run;
  cnt_t      h_cnt;
  cnt_t      v_cnt;
  logic      active;
  logic      hs_n;
  logic      vs_n;
  logic      frame_end;
  logic      rd_q;
  logic      hs_q;
  logic      vs_q;
  logic      uf_event;

  assign run = (state == ST_RUN);

  vid_hv_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_hv_counter (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hs_n      (hs_n),
    .vs_n      (vs_n),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Enable is only honoured at the last clock of a frame so frames are never cut short.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (enable) state_next = ST_RUN;
      ST_RUN:   if (frame_end && !enable) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign pix_rd      = run && active;
  assign frame_start = pix_rd && (h_cnt == '0) && (v_cnt == '0);
  assign busy        = (state != ST_IDLE);
  assign uf_event    = rd_q && !pix_valid;

  // Stage 1 tracks the cycle in which upstream answers; stage 2 drives the pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hdmi_de <= 1'b0;
      hdmi_hs <= 1'b1;
      hdmi_vs <= 1'b1;
      hdmi_d  <= '0;
    end else begin
      rd_q    <= pix_rd;
      hs_q    <= hs_n;
      vs_q    <= vs_n;
      hdmi_de <= rd_q;
      hdmi_hs <= hs_q;
      hdmi_vs <= vs_q;
      hdmi_d  <= rd_q ? (pix_valid ? pix_data : UFLOW_COLOR) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow <= 1'b0;
    end else if (uf_event) begin
      underflow <= 1'b1;
    end else if (frame_start) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdmi_tx_out.sv
// Scoreboard bench for hdmi_tx_out on a shrunken 16x10 raster: a timing model
// pushes expected pixels as upstream answers, a monitor pops them on hdmi_de.
module tb_hdmi_tx_out;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] UF_COLOR = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        pix_rd;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        hdmi_de;
  logic        hdmi_hs;
  logic        hdmi_vs;
  logic [23:0] hdmi_d;
  logic        frame_start;
  logic        underflow;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state (values describe the current cycle after each negedge update)
  int          m_state = 0;
  int          m_h = 0;
  int          m_v = 0;
  int          m_drain = 0;
  bit          m_uf = 0;
  bit          uf_pend = 0;
  bit          m_rd, m_fs, m_hs, m_vs, uf_next;
  bit          s1_de = 0, s1_hs = 1, s1_vs = 1;
  bit          s2_de = 0, s2_hs = 1, s2_vs = 1;
  logic [23:0] exp_q[$];
  bit          resp_valid = 0;
  logic [23:0] resp_data = '0;
  bit          drop_armed = 0;
  int          drop_h = 0;
  int          drop_v = 0;
  bit          spurious = 0;

  initial forever #5 clk = ~clk;

  hdmi_tx_out #(
    .H_ACTIVE    (HA),
    .H_FP        (HF),
    .H_SYNC      (HS),
    .H_BP        (HB),
    .V_ACTIVE    (VA),
    .V_FP        (VF),
    .V_SYNC      (VS),
    .V_BP        (VB),
    .UFLOW_COLOR (UF_COLOR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pix_rd      (pix_rd),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .hdmi_de     (hdmi_de),
    .hdmi_hs     (hdmi_hs),
    .hdmi_vs     (hdmi_vs),
    .hdmi_d      (hdmi_d),
    .frame_start (frame_start),
    .underflow   (underflow),
    .busy        (busy)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_model(input int st, input int h, input int v, input int max_cycles, input string name);
    bit found = 0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      if (m_state == st && m_h == h && m_v == v) found = 1;
      else apply_stimulus(1);
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: timed out waiting for state %0d at (%0d,%0d)", name, st, h, v);
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    bit found = 0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      if (m_state == 0) found = 1;
      else apply_stimulus(1);
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: timed out waiting for idle", name);
    end
  endtask

  // Timing model and upstream responder decision, evaluated mid-cycle
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check_output("rst_pix_rd", pix_rd, 0);
      check_output("rst_de", hdmi_de, 0);
      check_output("rst_hs", hdmi_hs, 1);
      check_output("rst_vs", hdmi_vs, 1);
      check_output("rst_d", hdmi_d, 0);
      check_output("rst_frame_start", frame_start, 0);
      check_output("rst_underflow", underflow, 0);
      check_output("rst_busy", busy, 0);
      m_state = 0; m_h = 0; m_v = 0; m_drain = 0;
      m_uf = 0; uf_pend = 0;
      s1_de = 0; s1_hs = 1; s1_vs = 1;
      s2_de = 0; s2_hs = 1; s2_vs = 1;
      exp_q.delete();
      resp_valid = 0;
      resp_data = '0;
    end else begin
      m_rd = (m_state == 1) && (m_h < HA) && (m_v < VA);
      m_fs = m_rd && (m_h == 0) && (m_v == 0);
      m_hs = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
      m_vs = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
      check_output("pix_rd", pix_rd, m_rd);
      check_output("frame_start", frame_start, m_fs);
      check_output("busy", busy, m_state != 0);
      check_output("hdmi_de", hdmi_de, s2_de);
      check_output("hdmi_hs", hdmi_hs, s2_hs);
      check_output("hdmi_vs", hdmi_vs, s2_vs);
      check_output("underflow", underflow, m_uf);
      uf_next = uf_pend ? 1'b1 : (m_fs ? 1'b0 : m_uf);
      if (m_rd) begin
        if (drop_armed && m_h == drop_h && m_v == drop_v) begin
          resp_valid = 0;
          resp_data  = 24'h123456;
          drop_armed = 0;
          exp_q.push_back(UF_COLOR);
        end else begin
          resp_valid = 1;
          resp_data  = {4'h0, 10'(m_v), 10'(m_h)};
          exp_q.push_back({4'h0, 10'(m_v), 10'(m_h)});
        end
      end else begin
        resp_valid = spurious;
        resp_data  = spurious ? 24'hABCDEF : 24'h0;
      end
      uf_pend = m_rd && !resp_valid;
      m_uf = uf_next;
      s2_de = s1_de; s2_hs = s1_hs; s2_vs = s1_vs;
      s1_de = m_rd;  s1_hs = m_hs;  s1_vs = m_vs;
      case (m_state)
        0: begin
          if (enable) m_state = 1;
          m_h = 0; m_v = 0;
        end
        1: begin
          if (m_h == HT - 1 && m_v == VT - 1 && !enable) begin
            m_state = 2;
            m_drain = 0;
          end
          if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
          end else begin
            m_h = m_h + 1;
          end
        end
        default: begin
          if (m_drain == 1) m_state = 0;
          m_drain = 1;
          m_h = 0; m_v = 0;
        end
      endcase
    end
  end

  // Upstream answers one cycle after the request
  initial forever begin
    @(posedge clk);
    #1;
    pix_valid = resp_valid;
    pix_data  = resp_data;
  end

  // Monitor: pops one expected pixel per DE clock, blank bus otherwise
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (hdmi_de) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL hdmi_d_unexpected: got %0h with no pixel pending", hdmi_d);
        end else begin
          check_output("hdmi_d", hdmi_d, exp_q.pop_front());
        end
      end else begin
        check_output("hdmi_d_blank", hdmi_d, 0);
      end
    end
  end

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    apply_stimulus(3);
    reset = 1'b1;
    apply_stimulus(3);

    $display("[TB] pattern frames");
    enable = 1'b1;
    apply_stimulus(2 * FRAME + 7);

    $display("[TB] dropped pixel");
    wait_model(1, 0, 1, 2 * FRAME, "wait_drop_arm");
    drop_h = 3;
    drop_v = 2;
    drop_armed = 1;
    wait_model(1, 0, 4, 2 * FRAME, "wait_after_drop");
    check_output("underflow_sticky", underflow, 1);
    wait_model(1, 1, 0, 2 * FRAME, "wait_next_frame");
    check_output("underflow_cleared", underflow, 0);

    $display("[TB] spurious valid in blanking");
    spurious = 1;
    apply_stimulus(FRAME);
    check_output("underflow_spurious", underflow, 0);
    spurious = 0;

    $display("[TB] enable drop mid-frame");
    wait_model(1, 0, 3, 2 * FRAME, "wait_v3");
    enable = 1'b0;
    apply_stimulus(FRAME / 2);
    check_output("busy_mid_frame", busy, 1);
    wait_idle(2 * FRAME, "wait_drain");
    check_output("idle_busy", busy, 0);
    check_output("idle_hs", hdmi_hs, 1);
    check_output("idle_vs", hdmi_vs, 1);
    check_output("idle_de", hdmi_de, 0);

    $display("[TB] reset mid-frame");
    enable = 1'b1;
    wait_model(1, 5, 3, 2 * FRAME, "wait_reset_point");
    #1;
    reset = 1'b0;
    #1;
    check_output("async_pix_rd", pix_rd, 0);
    check_output("async_de", hdmi_de, 0);
    check_output("async_hs", hdmi_hs, 1);
    check_output("async_vs", hdmi_vs, 1);
    check_output("async_d", hdmi_d, 0);
    check_output("async_busy", busy, 0);
    apply_stimulus(3);
    enable = 1'b0;
    reset = 1'b1;
    apply_stimulus(5);
    enable = 1'b1;
    wait_model(1, 0, 0, 10, "wait_restart");
    check_output("restart_frame_start", frame_start, 1);
    check_output("restart_pix_rd", pix_rd, 1);
    apply_stimulus(FRAME / 2);
    enable = 1'b0;
    wait_idle(2 * FRAME, "wait_final_idle");
    apply_stimulus(3);
    check_output("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
